// File: rtl/udma_evt_serializer.sv
// Event serializer: per-source saturating pending counters, round-robin arbiter,
// and a registered valid/ready output slot carrying 8-bit event IDs.
module udma_evt_serializer #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned EVT_ID_BASE = 0,
  parameter int unsigned CNT_W       = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_SRC-1:0] evt_i,
  output logic             evt_valid_o,
  output logic [7:0]       evt_data_o,
  input  logic             evt_ready_i,
  output logic [N_SRC-1:0] overflow_o,
  input  logic [N_SRC-1:0] overflow_clr_i,
  output logic             busy_o
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_VALID = 1'b1;

  logic                        state_q, state_d;
  logic [7:0]                  data_q, data_d;
  logic [IDX_W-1:0]            rr_q, rr_d;
  logic [N_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0]            ovf_q, ovf_d;

  logic [N_SRC-1:0] req_c;
  logic [N_SRC-1:0] dec_c;
  logic             gnt_vld_c;
  logic [IDX_W-1:0] gnt_idx_c;
  logic             grant_c;
  int unsigned      sum_c;
  logic [IDX_W-1:0] idx_c;

  // Requests come only from registered counters, so a fresh pulse waits one cycle.
  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      req_c[i] = (cnt_q[i] != '0);
    end
  end

  // Round-robin search starting at rr_q, wrapping modulo N_SRC.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    sum_c     = 0;
    idx_c     = '0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      sum_c = 32'(rr_q) + off;
      if (sum_c >= N_SRC) begin
        sum_c = sum_c - N_SRC;
      end
      idx_c = IDX_W'(sum_c);
      if (!gnt_vld_c && req_c[idx_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = idx_c;
      end
    end
  end

  // Output slot next-state logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rr_d    = rr_q;
    grant_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld_c) begin
          grant_c = 1'b1;
        end
      end
      ST_VALID: begin
        if (evt_ready_i) begin
          if (gnt_vld_c) begin
            grant_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_c) begin
      state_d = ST_VALID;
      data_d  = 8'(EVT_ID_BASE) + 8'(gnt_idx_c);
      rr_d    = (32'(gnt_idx_c) == N_SRC - 1) ? '0 : gnt_idx_c + IDX_W'(1);
    end
  end

  // Pending counters saturate; an event arriving at max with no grant is dropped and flagged.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~overflow_clr_i;
    dec_c = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      dec_c[i] = grant_c && (gnt_idx_c == IDX_W'(i));
      if (evt_i[i] && !dec_c[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (!evt_i[i] && dec_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid_o = (state_q == ST_VALID);
  assign evt_data_o  = data_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q == ST_VALID) || (|cnt_q);

endmodule

// File: tb/tb_udma_evt_serializer.sv
// Directed bench: instance A uses ID base 0x20, instance B base 0; both share stimulus.
module tb_udma_evt_serializer;

  logic       clk;
  logic       rstn;
  logic       rdy;
  logic [7:0] evt;
  logic [7:0] clr;
  logic       va, vb, busya, busyb;
  logic [7:0] da, db, ovfa, ovfb;
  int         checks = 0;
  int         errors = 0;
  int         n_acc;

  udma_evt_serializer #(.N_SRC(8), .EVT_ID_BASE(32'h20), .CNT_W(2)) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .evt_i(evt), .evt_valid_o(va), .evt_data_o(da),
    .evt_ready_i(rdy), .overflow_o(ovfa), .overflow_clr_i(clr), .busy_o(busya)
  );

  udma_evt_serializer #(.N_SRC(8), .EVT_ID_BASE(0), .CNT_W(2)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .evt_i(evt), .evt_valid_o(vb), .evt_data_o(db),
    .evt_ready_i(rdy), .overflow_o(ovfb), .overflow_clr_i(clr), .busy_o(busyb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; evt = '0; rdy = 1'b1; clr = '0;
    repeat (3) nxt();
    chk("rst_valid_a", 32'(va), 32'(0));
    chk("rst_valid_b", 32'(vb), 32'(0));
    chk("rst_data_a", 32'(da), 32'(0));
    chk("rst_data_b", 32'(db), 32'(0));
    chk("rst_ovf_a", 32'(ovfa), 32'(0));
    chk("rst_ovf_b", 32'(ovfb), 32'(0));
    chk("rst_busy_a", 32'(busya), 32'(0));
    chk("rst_busy_b", 32'(busyb), 32'(0));
    rstn = 1'b1;
    nxt();

    // Single pulse on source 3: valid two cycles later for one cycle.
    evt = 8'h08;
    nxt(); evt = '0;
    chk("t1_valid_t1", 32'(va), 32'(0));
    chk("t1_busy_t1", 32'(busya), 32'(1));
    nxt();
    chk("t1_valid_t2", 32'(va), 32'(1));
    chk("t1_data_a", 32'(da), 32'h23);
    chk("t1_data_b", 32'(db), 32'h03);
    nxt();
    chk("t1_valid_t3", 32'(va), 32'(0));
    chk("t1_busy_a_t3", 32'(busya), 32'(0));
    chk("t1_busy_b_t3", 32'(busyb), 32'(0));

    // Backpressure: source 5 held stable for 6 stalled cycles.
    evt = 8'h20; rdy = 1'b0;
    nxt(); evt = '0;
    nxt();
    for (int i = 0; i < 6; i++) begin
      chk("t2_hold_valid", 32'(vb), 32'(1));
      chk("t2_hold_data", 32'(db), 32'h05);
      nxt();
    end
    rdy = 1'b1;
    chk("t2_acc_valid", 32'(vb), 32'(1));
    chk("t2_acc_data", 32'(db), 32'h05);
    nxt();
    chk("t2_drop_valid", 32'(vb), 32'(0));

    // Round-robin: rr=6, sources 0,1,2 then 0 and 2.
    evt = 8'h07;
    nxt(); evt = '0;
    chk("t3_idle", 32'(vb), 32'(0));
    nxt();
    chk("t3_v0", 32'(vb), 32'(1));
    chk("t3_d0", 32'(db), 32'h00);
    nxt();
    chk("t3_d1", 32'(db), 32'h01);
    nxt();
    chk("t3_d2", 32'(db), 32'h02);
    nxt();
    chk("t3_end", 32'(vb), 32'(0));
    evt = 8'h05;
    nxt(); evt = '0;
    nxt();
    chk("t3_rr_v", 32'(vb), 32'(1));
    chk("t3_rr_first", 32'(db), 32'h00);
    nxt();
    chk("t3_rr_second", 32'(db), 32'h02);
    nxt();
    chk("t3_rr_end", 32'(vb), 32'(0));

    // Overflow on source 1 with the slot stalled.
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      evt = 8'h02;
      if (i == 4) chk("t4_no_ovf_yet", 32'(ovfb), 32'(0));
      nxt();
    end
    evt = '0;
    chk("t4_ovf_set", 32'(ovfb), 32'h02);
    chk("t4_ovf_valid", 32'(vb), 32'(1));
    chk("t4_ovf_data", 32'(db), 32'h01);
    rdy = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (vb && db == 8'h01) n_acc++;
      nxt();
    end
    chk("t4_delivered", 32'(n_acc), 32'(4));
    chk("t4_busy_after", 32'(busyb), 32'(0));
    chk("t4_ovf_sticky", 32'(ovfb), 32'h02);
    clr = 8'h02;
    nxt(); clr = '0;
    chk("t4_ovf_clr", 32'(ovfb), 32'h00);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      evt = 8'h02;
      nxt();
    end
    chk("t4_ovf_again", 32'(ovfb), 32'h02);
    evt = 8'h02; clr = 8'h02;
    nxt(); evt = '0; clr = '0;
    chk("t4_set_wins", 32'(ovfb), 32'h02);
    clr = 8'h02;
    nxt(); clr = '0;
    chk("t4_ovf_clr2", 32'(ovfb), 32'h00);
    rdy = 1'b1;
    repeat (6) nxt();
    chk("t4_drained", 32'(busyb), 32'(0));

    // Saturation: all sources every cycle, rr starts at 2.
    for (int k = 0; k < 22; k++) begin
      evt = (k < 20) ? 8'hFF : 8'h00;
      if (k < 2) begin
        chk("t5_startup", 32'(vb), 32'(0));
      end else begin
        chk("t5_valid", 32'(vb), 32'(1));
        chk("t5_data", 32'(db), 32'(k % 8));
      end
      nxt();
    end
    chk("t5_ovf_all", 32'(ovfb), 32'hFF);

    // Asynchronous reset during a stalled handshake.
    rdy = 1'b0;
    nxt();
    chk("t6_pre_valid", 32'(vb), 32'(1));
    chk("t6_pre_busy", 32'(busyb), 32'(1));
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_a", 32'(va), 32'(0));
    chk("t6_async_b", 32'(vb), 32'(0));
    nxt(); nxt();
    rstn = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("t6_post_valid", 32'(vb), 32'(0));
      chk("t6_post_busy", 32'(busyb), 32'(0));
    end
    chk("t6_post_ovf", 32'(ovfb), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
